filter_decimator_fifo: RTL and testbench
========================================

// Module: filter_decimator_fifo
// PURPOSE
//   Downstream stage of the 3-tap digital filter. Takes the 8-bit filter output
//   sample stream, averages each block of 2**DECIM_LOG2 valid samples into one
//   decimated sample, and buffers the results in a small FIFO. The FIFO drains
//   over a valid/ready handshake towards the display/readout logic.
// PARAMETERS
//   DATA_W      8  sample width, for both input and output
//   DECIM_LOG2  2  log2 of the decimation factor (DECIM = 4)
//   FIFO_DEPTH  4  FIFO entries; must be a power of 2
// PORTS
//   clk         in   1               system clock, rising edge
//   reset       in   1               asynchronous, active-high reset
//   clear       in   1               synchronous clear of all state
//   in_valid    in   1               in_data is a new filter sample this cycle
//   in_data     in   DATA_W          filter output sample, unsigned
//   out_valid   out  1               FIFO non-empty; out_data holds the head entry
//   out_data    out  DATA_W          head of FIFO, first-word-fall-through
//   out_ready   in   1               consumer accepts out_data this cycle
//   fill_level  out  log2(DEPTH)+1   number of entries currently held in the FIFO
//   overflow    out  1               sticky flag: a decimated result was dropped
// BEHAVIOUR
//   Reset (async, active-high):
//     - Accumulator, phase counter, FIFO pointers and memory all cleared to 0.
//     - Outputs after reset: out_valid=0, out_data=0, fill_level=0, overflow=0.
//   Accumulator:
//     - Width is DATA_W+DECIM_LOG2, so it never wraps.
//     - On in_valid: acc += in_data and phase increments.
//     - Cycles without in_valid hold acc and phase unchanged. Gaps are allowed.
//   Decimation:
//     - Triggered by in_valid while phase == DECIM-1.
//     - result = (acc + in_data) >> DECIM_LOG2, truncated (floor).
//     - In the same cycle, acc and phase return to 0 and a push request is raised.
//   Latency:
//     - A result is written at the edge that registers the DECIM-th sample.
//     - out_valid rises the cycle after that sample is presented.
//   FIFO:
//     - Write and read pointers wrap modulo FIFO_DEPTH.
//     - fill_level = number of entries, in 0..FIFO_DEPTH.
//   Pop:
//     - A pop occurs when out_valid && out_ready.
//     - out_ready while empty is ignored.
//   Push:
//     - When not full, a push writes the result and fill_level increments.
//   Full:
//     - Push without pop: the result is dropped and overflow is set to 1.
//     - FIFO contents are unchanged; overflow stays set until reset or clear.
//     - Push and pop in the same cycle: both happen and fill_level stays at DEPTH.
//   Empty:
//     - Push and pop in the same cycle cannot occur, because out_valid=0.
//     - The pushed word appears on out_data in the next cycle.
//   Not full and not empty:
//     - Simultaneous push and pop leaves fill_level unchanged.
//   clear:
//     - Takes priority over everything else in that cycle.
//     - acc, phase, pointers, fill_level and overflow go to 0 at the next edge.
//     - No push or pop occurs in that cycle.
//   out_data while empty:
//     - Holds the last memory word at rd_ptr; it is meaningful only with out_valid.
//   Reset mid-operation:
//     - A partial block is discarded.
//     - Decimation restarts with the first in_valid after reset is released.
// TESTING
//   1. in 10,20,30,40 consecutive -> one cycle later out_valid=1, out_data=25,
//      fill_level=1.
//   2. in 255 x4 -> out 255 (no accumulator wrap); in 1,1,1,2 -> out 1
//      (floor of 5/4).
//   3. in_valid gaps: 8,_,_,8,8,_,8 -> exactly one result, 8, and no result
//      before the 4th valid sample.
//   4. out_ready=0, feed 5 blocks of value k=1..5 -> fill_level=4, overflow=1;
//      then out_ready=1 -> reads 1,2,3,4, then out_valid=0.
//   5. FIFO full with out_ready=1 while the 5th result arrives -> pop of 1 and
//      push of 5 together, fill_level stays 4, overflow=0.
//   6. 2 samples in, then reset pulse mid-block -> outputs 0; then 4,4,4,4 ->
//      out 4. Repeat using clear instead of reset: same result.

Source files
------------

// File: rtl/filter_decimator_fifo.sv
// Block averager and output FIFO behind the 3-tap filter.
// Each run of 2**DECIM_LOG2 valid samples becomes one averaged word.
module filter_decimator_fifo #(
   parameter int DATA_W     = 8,
   parameter int DECIM_LOG2 = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ACC_W = DATA_W + DECIM_LOG2;
   localparam logic [DECIM_LOG2-1:0] LAST_PHASE = {DECIM_LOG2{1'b1}};
   localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

   logic [ACC_W-1:0]      acc;
   logic [ACC_W-1:0]      acc_sum;
   logic [DECIM_LOG2-1:0] phase;
   logic [DATA_W-1:0]     result;
   logic [DATA_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        count;
   logic                  block_done;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  wr_en;

   // Block sum, floor average and FIFO handshake decisions.
   always_comb begin
      acc_sum    = acc + ACC_W'(in_data);
      result     = acc_sum[ACC_W-1 -: DATA_W];
      block_done = in_valid && (phase == LAST_PHASE);
      full       = (count == DEPTH_L);
      out_valid  = (count != '0);
      pop        = out_valid && out_ready && !clear;
      push       = block_done && !clear;
      wr_en      = push && (!full || pop);
   end

   // Accumulate samples; restart the block when it completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc   <= '0;
         phase <= '0;
      end else if (clear) begin
         acc   <= '0;
         phase <= '0;
      end else if (in_valid) begin
         if (block_done) begin
            acc   <= '0;
            phase <= '0;
         end else begin
            acc   <= acc_sum;
            phase <= phase + DECIM_LOG2'(1);
         end
      end
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= result;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky drop flag: a result arrived with no room and no pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (clear) begin
         overflow <= 1'b0;
      end else if (push && full && !pop) begin
         overflow <= 1'b1;
      end
   end

   assign out_data   = mem[rd_ptr];
   assign fill_level = count;

endmodule

// File: tb/tb_filter_decimator_fifo.sv
// Scoreboard bench for filter_decimator_fifo.
// Reference keeps raw sample blocks and a FIFO occupancy count.
module tb_filter_decimator_fifo;

   localparam int DEPTH = 4;
   localparam int DECIM = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [2:0] fill_level;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;

   int unsigned blk[$];
   int unsigned exp_q[$];
   int          mdl_cnt = 0;
   bit          mdl_ovf = 1'b0;
   bit          m_pop;
   bit          m_full;
   int unsigned m_sum;

   filter_decimator_fifo #(
      .DATA_W(8),
      .DECIM_LOG2(2),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .in_valid(in_valid),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .fill_level(fill_level),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: average of every DECIM valid samples, bounded FIFO.
   always @(posedge clk or posedge reset) begin
      if (reset || clear) begin
         blk.delete();
         exp_q.delete();
         mdl_cnt = 0;
         mdl_ovf = 1'b0;
      end else begin
         m_full = (mdl_cnt == DEPTH);
         m_pop  = (mdl_cnt > 0) && out_ready;
         if (m_pop) mdl_cnt--;
         if (in_valid) begin
            blk.push_back(int'(in_data));
            if (blk.size() == DECIM) begin
               m_sum = 0;
               foreach (blk[i]) m_sum += blk[i];
               blk.delete();
               if (!m_full || m_pop) begin
                  exp_q.push_back(m_sum / DECIM);
                  mdl_cnt++;
               end else begin
                  mdl_ovf = 1'b1;
               end
            end
         end
      end
   end

   // Monitor: compare outputs mid-cycle, retire words the DUT hands off.
   always @(negedge clk) begin
      if (!reset) begin
         check("out_valid", out_valid, (mdl_cnt != 0));
         check("fill_level", fill_level, mdl_cnt);
         check("overflow", overflow, mdl_ovf);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL out_data: got %0d with no expected word", out_data);
            end else begin
               check("out_data", out_data, exp_q[0]);
               if (out_ready && !clear) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic cyc(bit v, int unsigned d, bit r);
      in_valid  = v;
      in_data   = 8'(d);
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n, bit r);
      repeat (n) cyc(1'b0, 0, r);
   endtask

   task automatic block4(int unsigned v, bit r);
      repeat (DECIM) cyc(1'b1, v, r);
   endtask

   initial begin
      int rp;
      reset     = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_fill", fill_level, 0);
      check("rst_ovf", overflow, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      cyc(1'b1, 10, 1'b0);
      cyc(1'b1, 20, 1'b0);
      cyc(1'b1, 30, 1'b0);
      check("t1_early", out_valid, 0);
      cyc(1'b1, 40, 1'b0);
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 25);
      check("t1_fill", fill_level, 1);
      idle(2, 1'b1);

      block4(255, 1'b0);
      check("t2_max", out_data, 255);
      idle(2, 1'b1);
      cyc(1'b1, 1, 1'b0);
      cyc(1'b1, 1, 1'b0);
      cyc(1'b1, 1, 1'b0);
      cyc(1'b1, 2, 1'b0);
      check("t2_floor", out_data, 1);
      idle(2, 1'b1);

      cyc(1'b1, 8, 1'b0);
      idle(2, 1'b0);
      cyc(1'b1, 8, 1'b0);
      cyc(1'b1, 8, 1'b0);
      idle(1, 1'b0);
      check("t3_early", out_valid, 0);
      cyc(1'b1, 8, 1'b0);
      check("t3_valid", out_valid, 1);
      check("t3_data", out_data, 8);
      check("t3_fill", fill_level, 1);
      idle(2, 1'b1);

      for (int k = 1; k <= 5; k++) block4(k, 1'b0);
      check("t4_fill", fill_level, 4);
      check("t4_ovf", overflow, 1);
      for (int j = 1; j <= 4; j++) begin
         check("t4_read", out_data, j);
         cyc(1'b0, 0, 1'b1);
      end
      check("t4_empty", out_valid, 0);

      clear = 1'b1;
      cyc(1'b0, 0, 1'b0);
      clear = 1'b0;
      check("clr_ovf", overflow, 0);
      for (int k = 1; k <= 4; k++) block4(k, 1'b0);
      repeat (3) cyc(1'b1, 5, 1'b0);
      cyc(1'b1, 5, 1'b1);
      check("t5_fill", fill_level, 4);
      check("t5_ovf", overflow, 0);
      for (int j = 2; j <= 5; j++) begin
         check("t5_read", out_data, j);
         cyc(1'b0, 0, 1'b1);
      end
      check("t5_empty", out_valid, 0);

      cyc(1'b1, 9, 1'b0);
      cyc(1'b1, 9, 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      #2;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_data", out_data, 0);
      check("t6_rst_fill", fill_level, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      block4(4, 1'b0);
      check("t6_rst_out", out_data, 4);
      check("t6_rst_cnt", fill_level, 1);
      idle(2, 1'b1);

      cyc(1'b1, 9, 1'b0);
      cyc(1'b1, 9, 1'b0);
      clear = 1'b1;
      cyc(1'b1, 9, 1'b0);
      clear = 1'b0;
      check("t6_clr_valid", out_valid, 0);
      block4(4, 1'b0);
      check("t6_clr_out", out_data, 4);
      check("t6_clr_cnt", fill_level, 1);
      idle(2, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         rp    = (i < 1500) ? 1 : 5;
         clear = ($urandom_range(0, 299) == 0);
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 255),
             $urandom_range(0, 7) < rp);
      end
      clear = 1'b0;
      idle(10, 1'b1);
      check("final_empty", out_valid, 0);
      check("final_queue", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
